// File: rtl/scan_chain_ctrl.sv
// Load/capture/unload sequencer for an attached mux-D scan chain of CHAIN_LEN flops.
// Define SCAN_CHAIN_CTRL_CMP_EN to compare the unloaded response against EXP.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] PAT,
    input  logic [CHAIN_LEN-1:0] EXP,
    input  logic                 SO,
    output logic                 SI,
    output logic                 SE,
    output logic                 SP,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESP,
    output logic                 MISMATCH
);
    localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CAPT   = 3'd2,
        UNLOAD = 3'd3,
        FIN    = 3'd4
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CHAIN_LEN-1:0] r_pat;
    logic [CHAIN_LEN-1:0] r_resp;
    logic                 r_se;
    logic                 r_sp;
    logic                 r_busy;
    logic                 r_done;

    logic [CHAIN_LEN-1:0] w_resp_shift;
    logic                 w_cnt_tc;
    logic                 w_abort;

    assign w_resp_shift = {r_resp[CHAIN_LEN-2:0], SO};
    assign w_cnt_tc     = (r_cnt == CNT_TC);
    assign w_abort      = ABORT && ((r_state == LOAD) || (r_state == CAPT) || (r_state == UNLOAD));

    // The pattern register drains to zero during LOAD and is cleared on abort,
    // so its MSB is a valid registered SI in every state.
    assign SI   = r_pat[CHAIN_LEN-1];
    assign SE   = r_se;
    assign SP   = r_sp;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign RESP = r_resp;

    // Sequencer: state, bit counter, pattern/response shifters and chain controls.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
            r_pat   <= {CHAIN_LEN{1'b0}};
            r_resp  <= {CHAIN_LEN{1'b0}};
            r_se    <= 1'b0;
            r_sp    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_abort) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
            r_pat   <= {CHAIN_LEN{1'b0}};
            r_se    <= 1'b0;
            r_sp    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_state <= LOAD;
                        r_cnt   <= CNT_ZERO;
                        r_pat   <= PAT;
                        r_se    <= 1'b1;
                        r_sp    <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_se   <= 1'b0;
                        r_sp   <= 1'b0;
                        r_busy <= 1'b0;
                    end
                end
                LOAD: begin
                    r_pat <= {r_pat[CHAIN_LEN-2:0], 1'b0};
                    if (w_cnt_tc) begin
                        r_state <= CAPT;
                        r_cnt   <= CNT_ZERO;
                        r_se    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                CAPT: begin
                    r_state <= UNLOAD;
                    r_cnt   <= CNT_ZERO;
                    r_se    <= 1'b1;
                end
                UNLOAD: begin
                    r_resp <= w_resp_shift;
                    if (w_cnt_tc) begin
                        r_state <= FIN;
                        r_cnt   <= CNT_ZERO;
                        r_se    <= 1'b0;
                        r_sp    <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_se    <= 1'b0;
                    r_sp    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_pat   <= {CHAIN_LEN{1'b0}};
                    r_se    <= 1'b0;
                    r_sp    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_CHAIN_CTRL_CMP_EN
    logic [CHAIN_LEN-1:0] r_exp;
    logic                 r_mismatch;

    // Expected response is latched at START; the compare result lives only in FIN.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_exp      <= {CHAIN_LEN{1'b0}};
            r_mismatch <= 1'b0;
        end else if ((r_state == IDLE) && START) begin
            r_exp      <= EXP;
            r_mismatch <= 1'b0;
        end else if ((r_state == UNLOAD) && !ABORT && w_cnt_tc) begin
            r_mismatch <= (w_resp_shift != r_exp);
        end else begin
            r_mismatch <= 1'b0;
        end
    end

    assign MISMATCH = r_mismatch;
`else
    assign MISMATCH = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl: sequence-level reference model plus directed and random stimulus.
module tb_scan_chain_ctrl;
    localparam int N  = 16;
    localparam int N2 = 2;
`ifdef SCAN_CHAIN_CTRL_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic          CK = 1'b0;
    logic          RN = 1'b0;
    logic          START = 1'b0;
    logic          ABORT = 1'b0;
    logic [N-1:0]  PAT = '0;
    logic [N-1:0]  EXP = '0;
    logic          SO;
    logic          SI, SE, SP, BUSY, DONE, MISMATCH;
    logic [N-1:0]  RESP;

    logic          START2 = 1'b0;
    logic          ABORT2 = 1'b0;
    logic [N2-1:0] PAT2 = '0;
    logic [N2-1:0] EXP2 = '0;
    logic          SO2;
    logic          SI2, SE2, SP2, BUSY2, DONE2, MISMATCH2;
    logic [N2-1:0] RESP2;

    int checks = 0;
    int errors = 0;

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .CK(CK), .RN(RN), .START(START), .ABORT(ABORT), .PAT(PAT), .EXP(EXP), .SO(SO),
        .SI(SI), .SE(SE), .SP(SP), .BUSY(BUSY), .DONE(DONE), .RESP(RESP), .MISMATCH(MISMATCH)
    );

    scan_chain_ctrl #(.CHAIN_LEN(N2)) dut2 (
        .CK(CK), .RN(RN), .START(START2), .ABORT(ABORT2), .PAT(PAT2), .EXP(EXP2), .SO(SO2),
        .SI(SI2), .SE(SE2), .SP(SP2), .BUSY(BUSY2), .DONE(DONE2), .RESP(RESP2), .MISMATCH(MISMATCH2)
    );

    always #5 CK = ~CK;

    // Behavioural chains: shift SI in when SE, otherwise capture Q (or ~Q when inv_mode).
    logic [N-1:0]  ch = '0;
    logic [N2-1:0] ch2 = '0;
    logic          inv_mode = 1'b1;
    assign SO  = ch[N-1];
    assign SO2 = ch2[N2-1];

    always @(posedge CK) begin
        if (SP) ch <= SE ? {ch[N-2:0], SI} : (inv_mode ? ~ch : ch);
    end

    always @(posedge CK) begin
        if (SP2) ch2 <= SE2 ? {ch2[N2-2:0], SI2} : ch2;
    end

    // Reference: m_t is the cycle number within a sequence (0 = idle, 2N+2 = done cycle).
    int           m_t = 0;
    logic [N-1:0] m_pat = '0;
    logic [N-1:0] m_exp = '0;
    logic [N-1:0] m_resp = '0;

    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            m_t    <= 0;
            m_resp <= '0;
        end else if (m_t == 0) begin
            if (START) begin
                m_t   <= 1;
                m_pat <= PAT;
                m_exp <= EXP;
            end
        end else if (m_t <= 2*N+1 && ABORT) begin
            m_t <= 0;
        end else begin
            if (m_t >= N+2 && m_t <= 2*N+1) m_resp <= {m_resp[N-2:0], SO};
            m_t <= (m_t == 2*N+2) ? 0 : m_t + 1;
        end
    end

    function automatic logic e_se(input int t);
        return (t >= 1 && t <= N) || (t >= N+2 && t <= 2*N+1);
    endfunction
    function automatic logic e_sp(input int t);
        return (t >= 1 && t <= 2*N+1);
    endfunction
    function automatic logic e_si(input int t);
        return (t >= 1 && t <= N) ? m_pat[N-t] : 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, req, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge CK) begin
        chk("SE", 64'(SE), 64'(e_se(m_t)));
        chk("SP", 64'(SP), 64'(e_sp(m_t)));
        chk("SI", 64'(SI), 64'(e_si(m_t)));
        chk("BUSY", 64'(BUSY), 64'(m_t != 0));
        chk("DONE", 64'(DONE), 64'(m_t == 2*N+2));
        chk("RESP", 64'(RESP), 64'(m_resp));
        chk("MISMATCH", 64'(MISMATCH), 64'(CMP && (m_t == 2*N+2) && (m_resp != m_exp)));
    end

    // Drive START for the edge ending the current cycle; returns in cycle 1 of the sequence.
    task automatic pulse(input logic [N-1:0] p, input logic [N-1:0] e);
        START = 1'b1;
        PAT   = p;
        EXP   = e;
        @(negedge CK);
        START = 1'b0;
    endtask

    task automatic observe(input int ncyc, input int restart_c, output logic [N-1:0] si_s,
                           output int done_c, output int ndone, output logic mm_done);
        si_s = '0; done_c = -1; ndone = 0; mm_done = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c <= N) si_s[N-c] = SI;
            if (DONE) begin
                if (ndone == 0) begin
                    done_c  = c;
                    mm_done = MISMATCH;
                end
                ndone++;
            end
            if (c == restart_c) begin
                START = 1'b1;
                PAT   = 16'hFFFF;
            end
            if (c == restart_c + 2) START = 1'b0;
            @(negedge CK);
        end
    endtask

    logic [N-1:0] si_s;
    int           done_c, ndone;
    logic         mm_d;
    logic [7:0]   se2_obs, sp2_obs, done2_obs;
    logic [1:0]   si2_obs;

    initial begin
        repeat (3) @(negedge CK);
        chk("rst_SE", 64'(SE), 64'(0));
        chk("rst_BUSY", 64'(BUSY), 64'(0));
        chk("rst_RESP", 64'(RESP), 64'(0));
        RN = 1'b1;
        @(negedge CK);

        // Inverting chain, PAT A5C3.
        inv_mode = 1'b1;
        pulse(16'hA5C3, 16'h0000);
        observe(2*N+4, -10, si_s, done_c, ndone, mm_d);
        chk("a5c3_si_stream", 64'(si_s), 64'(16'hA5C3));
        chk("a5c3_done_cycle", 64'(done_c), 64'(34));
        chk("a5c3_ndone", 64'(ndone), 64'(1));
        chk("a5c3_resp", 64'(RESP), 64'(16'h5A3C));

        // Compare: hold chain, matching then mismatching expectation.
        inv_mode = 1'b0;
        pulse(16'h00FF, 16'h00FF);
        observe(2*N+4, -10, si_s, done_c, ndone, mm_d);
        chk("cmp_match", 64'(mm_d), 64'(0));
        chk("cmp_resp", 64'(RESP), 64'(16'h00FF));
        pulse(16'h00FF, 16'h01FF);
        observe(2*N+4, -10, si_s, done_c, ndone, mm_d);
        chk("cmp_miss", 64'(mm_d), 64'(CMP ? 1 : 0));

        // Abort in LOAD cycle 5, restart the next cycle.
        pulse(16'h1234, 16'h0000);
        repeat (4) @(negedge CK);
        ABORT = 1'b1;
        @(negedge CK);
        ABORT = 1'b0;
        chk("abort_SE", 64'(SE), 64'(0));
        chk("abort_SP", 64'(SP), 64'(0));
        chk("abort_BUSY", 64'(BUSY), 64'(0));
        pulse(16'hBEEF, 16'h0000);
        chk("restart_BUSY", 64'(BUSY), 64'(1));
        observe(2*N+4, -10, si_s, done_c, ndone, mm_d);
        chk("restart_done_cycle", 64'(done_c), 64'(2*N+2));

        // START re-pulsed during UNLOAD is ignored.
        inv_mode = 1'b1;
        pulse(16'h0F0F, 16'h0000);
        observe(2*N+6, N+4, si_s, done_c, ndone, mm_d);
        chk("restart_ign_done_cycle", 64'(done_c), 64'(2*N+2));
        chk("restart_ign_ndone", 64'(ndone), 64'(1));
        chk("restart_ign_resp", 64'(RESP), 64'(16'hF0F0));

        // Reset asserted during CAPT.
        pulse(16'h5555, 16'h0000);
        repeat (N) @(negedge CK);
        chk("capt_SP", 64'(SP), 64'(1));
        #2 RN = 1'b0;
        #1;
        chk("arst_SE", 64'(SE), 64'(0));
        chk("arst_SP", 64'(SP), 64'(0));
        chk("arst_BUSY", 64'(BUSY), 64'(0));
        chk("arst_RESP", 64'(RESP), 64'(0));
        @(negedge CK);
        RN = 1'b1;
        pulse(16'h3C3C, 16'h0000);
        chk("post_rst_BUSY", 64'(BUSY), 64'(1));
        observe(2*N+4, -10, si_s, done_c, ndone, mm_d);
        chk("post_rst_done_cycle", 64'(done_c), 64'(2*N+2));

        // CHAIN_LEN=2 instance, PAT 2'b10.
        START2 = 1'b1;
        PAT2   = 2'b10;
        EXP2   = 2'b10;
        @(negedge CK);
        START2 = 1'b0;
        se2_obs = '0; sp2_obs = '0; done2_obs = '0; si2_obs = '0;
        for (int c = 1; c <= 8; c++) begin
            se2_obs[c-1]   = SE2;
            sp2_obs[c-1]   = SP2;
            done2_obs[c-1] = DONE2;
            if (c <= 2) si2_obs[2-c] = SI2;
            if (DONE2) chk("n2_mismatch", 64'(MISMATCH2), 64'(0));
            @(negedge CK);
        end
        chk("n2_se", 64'(se2_obs), 64'(8'b0001_1011));
        chk("n2_sp", 64'(sp2_obs), 64'(8'b0001_1111));
        chk("n2_done", 64'(done2_obs), 64'(8'b0010_0000));
        chk("n2_si", 64'(si2_obs), 64'(2'b10));
        chk("n2_resp", 64'(RESP2), 64'(2'b10));

        // Random START/ABORT/pattern traffic checked by the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) inv_mode = ~inv_mode;
            START = ($urandom_range(0, 9) == 0);
            ABORT = ($urandom_range(0, 29) == 0);
            PAT   = N'($urandom);
            EXP   = ($urandom_range(0, 1) == 1) ? (inv_mode ? ~PAT : PAT) : N'($urandom);
            @(negedge CK);
        end
        START = 1'b0;
        ABORT = 1'b0;
        repeat (2*N+4) @(negedge CK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
